sprite_motion_ctrl: RTL and testbench
=====================================

# sprite_motion_ctrl

Frame-synchronous motion controller for the player sprite. It sits between the PS/2 keyboard decoder and the VGA sprite renderer. It converts key press/release events into a held-key mask, and sequences the sprite position (walk and jump) once per video frame. Positions change only on frame ticks, so the renderer never sees a mid-frame position change.

## Interface
Parameters:
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in pixels
- SPRITE_W, 32, sprite width
- SPRITE_H, 32, sprite height
- STEP, 4, pixels moved per frame per axis
- X_INIT, 304, reset X
- Y_INIT, 224, reset Y
- JUMP_H, 64, jump apex height in pixels (multiple of JUMP_STEP)
- JUMP_STEP, 8, vertical pixels per frame while jumping

Ports:
- i_clk  in  1  system clock; one clock domain only
- i_rst_n  in  1  reset, synchronous, active-low
- i_key_valid  in  1  one-cycle pulse: a decoded key event is present
- i_key_ascii  in  8  ASCII code of the event; valid with i_key_valid
- i_key_break  in  1  1 = release event, 0 = press event; valid with i_key_valid
- i_frame_tick  in  1  one-cycle pulse at the start of vertical blanking
- o_x_pos  out  10  sprite left edge
- o_y_pos  out  10  sprite top edge
- o_state  out  3  motion state: 0 IDLE, 1 WALK, 2 JUMP_UP, 3 JUMP_DN
- o_facing  out  2  0 right, 1 left, 2 up, 3 down
- o_upd  out  1  one-cycle pulse when a frame update is applied

## Operation
- Key map: 'w' 0x77 up, 'a' 0x61 left, 's' 0x73 down, 'd' 0x64 right, ' ' 0x20 jump. All other codes are ignored.
- Held mask (4 bits): a press of a direction key sets its bit; a release clears it. Repeated presses are idempotent.
- Jump request flag: set by a press of space; cleared when consumed or on any frame tick where it cannot be honoured.
- Axis intent: dx = right−left and dy = down−up, each in {−1, 0, +1}. Opposite keys held together give 0 on that axis.
- On each i_frame_tick the FSM evaluates, using mask and flag values registered before that cycle:
  - IDLE/WALK, jump flag set: record base_y = y, go to JUMP_UP, clear flag. Horizontal motion still applies on this tick.
  - IDLE/WALK, no jump: x += dx·STEP and y += dy·STEP. Next state is WALK if (dx, dy) ≠ 0, else IDLE.
  - JUMP_UP: y −= JUMP_STEP; x += dx·STEP; dy is ignored. Go to JUMP_DN when base_y − y reaches JUMP_H, or when y clamps at 0.
  - JUMP_DN: y += JUMP_STEP, never passing base_y; x += dx·STEP. When y = base_y, go to WALK if dx ≠ 0, else IDLE.
  - Space press while in JUMP_UP/JUMP_DN: flag is cleared on the next tick; no jump is queued.
- Clamp: arithmetic is done in 11-bit signed. X is limited to [0, H_ACTIVE−SPRITE_W] = [0, 608]; Y to [0, V_ACTIVE−SPRITE_H] = [0, 448]. Both results are saturated; they never wrap.
- Facing: updated on a tick only when motion is requested. Horizontal intent has priority: dx = +1 gives 0, dx = −1 gives 1. Otherwise dy = −1 gives 2 and dy = +1 gives 3. Jump alone leaves facing unchanged.

## Timing
- Reset values (sampled on an i_clk edge with i_rst_n = 0): o_x_pos = X_INIT, o_y_pos = Y_INIT, o_state = IDLE, o_facing = 0, o_upd = 0, mask = 0, jump flag = 0, base_y = Y_INIT.
- Key event latency: the mask/flag updates on the cycle after i_key_valid, and affects position at the next frame tick.
- If i_key_valid and i_frame_tick coincide, the tick uses the old mask; the event applies from the following tick.
- Frame update latency: o_x_pos, o_y_pos, o_state and o_facing change on the edge following the i_frame_tick cycle. o_upd is high for exactly that one cycle.
- Outputs are held constant between ticks.
- o_upd pulses on every tick, even when the position does not change.
- Reset asserted mid-jump: all state returns to reset values on that edge; the jump is abandoned.
- Back-to-back ticks (adjacent cycles) are each processed independently.

## Test plan
- Reset, then hold 'd', then 10 ticks → x = 304→344, state WALK, facing 0, o_upd pulses 10 times. Release 'd', then 1 tick → state IDLE, x = 344.
- Hold 'a' from reset for 80 ticks → x saturates at 0 with no wrap. Hold 'd' from 600 → x stops at 608.
- Hold 'a' and 'd' together, then tick → x unchanged, state IDLE, facing unchanged.
- Press space at y = 224, then 16 ticks → y falls to 160 over 8 ticks (JUMP_UP), then returns to 224 over 8 ticks (JUMP_DN), then IDLE. A second space press during the jump has no effect.
- Jump starting at y = 40 → y clamps at 0 after 5 ticks, enters JUMP_DN, returns to 40.
- Press 'd' in the same cycle as a tick → no motion on that tick; x += 4 on the next tick. Assert reset mid-jump → outputs return to (304, 224), IDLE, next cycle.

Source files
------------

// File: rtl/sprite_motion_ctrl.sv
// Player sprite motion controller: tracks held keys from decoded PS/2 events and
// advances walk/jump position once per video frame tick, saturating at screen edges.
module sprite_motion_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int SPRITE_W  = 32,
    parameter int SPRITE_H  = 32,
    parameter int STEP      = 4,
    parameter int X_INIT    = 304,
    parameter int Y_INIT    = 224,
    parameter int JUMP_H    = 64,
    parameter int JUMP_STEP = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_valid,
    input  logic [7:0] i_key_ascii,
    input  logic       i_key_break,
    input  logic       i_frame_tick,
    output logic [9:0] o_x_pos,
    output logic [9:0] o_y_pos,
    output logic [2:0] o_state,
    output logic [1:0] o_facing,
    output logic       o_upd
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WALK    = 3'd1,
        S_JUMP_UP = 3'd2,
        S_JUMP_DN = 3'd3
    } state_t;

    localparam logic signed [10:0] C_X_MAX  = 11'(H_ACTIVE - SPRITE_W);
    localparam logic signed [10:0] C_Y_MAX  = 11'(V_ACTIVE - SPRITE_H);
    localparam logic signed [10:0] C_STEP   = 11'(STEP);
    localparam logic signed [10:0] C_JSTEP  = 11'(JUMP_STEP);
    localparam logic signed [10:0] C_JUMP_H = 11'(JUMP_H);

    // Mask bit order: [0] up, [1] left, [2] down, [3] right
    logic [3:0]  r_mask;
    logic        r_jump;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [9:0]  r_base_y;
    state_t      r_state;
    logic [1:0]  r_facing;
    logic        r_upd;

    logic        w_left_only;
    logic        w_right_only;
    logic        w_up_only;
    logic        w_down_only;
    logic signed [10:0] w_dx_step;
    logic signed [10:0] w_dy_step;
    logic [9:0]  w_x_walk;
    logic [9:0]  w_y_walk;
    logic [9:0]  w_y_up;
    logic signed [10:0] w_y_dn_sum;
    logic signed [10:0] w_rise;
    logic [1:0]  w_facing_h;
    state_t      w_state_nxt;
    logic [9:0]  w_x_nxt;
    logic [9:0]  w_y_nxt;
    logic [9:0]  w_base_nxt;
    logic [1:0]  w_facing_nxt;

    function automatic logic [9:0] sat(input logic signed [10:0] v, input logic signed [10:0] hi);
        if (v[10])
            return '0;
        else if (v > hi)
            return hi[9:0];
        else
            return v[9:0];
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mask <= '0;
            r_jump <= 1'b0;
        end else begin
            // A tick always drops the request; a coincident space press re-arms it for the next tick.
            if (i_frame_tick)
                r_jump <= 1'b0;
            if (i_key_valid) begin
                case (i_key_ascii)
                    8'h77:   r_mask[0] <= ~i_key_break;
                    8'h61:   r_mask[1] <= ~i_key_break;
                    8'h73:   r_mask[2] <= ~i_key_break;
                    8'h64:   r_mask[3] <= ~i_key_break;
                    8'h20:   if (!i_key_break) r_jump <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_left_only  = r_mask[1] & ~r_mask[3];
        w_right_only = r_mask[3] & ~r_mask[1];
        w_up_only    = r_mask[0] & ~r_mask[2];
        w_down_only  = r_mask[2] & ~r_mask[0];
        w_dx_step    = w_right_only ? C_STEP : (w_left_only ? -C_STEP : '0);
        w_dy_step    = w_down_only  ? C_STEP : (w_up_only   ? -C_STEP : '0);
        w_x_walk     = sat($signed({1'b0, r_x}) + w_dx_step, C_X_MAX);
        w_y_walk     = sat($signed({1'b0, r_y}) + w_dy_step, C_Y_MAX);
        w_y_up       = sat($signed({1'b0, r_y}) - C_JSTEP, C_Y_MAX);
        w_y_dn_sum   = $signed({1'b0, r_y}) + C_JSTEP;
        w_rise       = $signed({1'b0, r_base_y}) - $signed({1'b0, w_y_up});
        w_facing_h   = w_right_only ? 2'd0 : (w_left_only ? 2'd1 : r_facing);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = w_x_walk;
        w_y_nxt      = r_y;
        w_base_nxt   = r_base_y;
        w_facing_nxt = w_facing_h;
        case (r_state)
            S_IDLE, S_WALK: begin
                if (r_jump) begin
                    w_base_nxt  = r_y;
                    w_state_nxt = S_JUMP_UP;
                end else begin
                    w_y_nxt     = w_y_walk;
                    w_state_nxt = (w_left_only | w_right_only | w_up_only | w_down_only) ? S_WALK : S_IDLE;
                    if (!(w_left_only | w_right_only)) begin
                        if (w_up_only)
                            w_facing_nxt = 2'd2;
                        else if (w_down_only)
                            w_facing_nxt = 2'd3;
                    end
                end
            end
            S_JUMP_UP: begin
                w_y_nxt = w_y_up;
                if (w_y_up == '0 || w_rise >= C_JUMP_H)
                    w_state_nxt = S_JUMP_DN;
            end
            S_JUMP_DN: begin
                if (w_y_dn_sum >= $signed({1'b0, r_base_y})) begin
                    w_y_nxt     = r_base_y;
                    w_state_nxt = (w_left_only | w_right_only) ? S_WALK : S_IDLE;
                end else begin
                    w_y_nxt = w_y_dn_sum[9:0];
                end
            end
            default: begin
                w_x_nxt      = r_x;
                w_facing_nxt = r_facing;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_x      <= 10'(X_INIT);
            r_y      <= 10'(Y_INIT);
            r_base_y <= 10'(Y_INIT);
            r_state  <= S_IDLE;
            r_facing <= 2'd0;
            r_upd    <= 1'b0;
        end else begin
            r_upd <= i_frame_tick;
            if (i_frame_tick) begin
                r_x      <= w_x_nxt;
                r_y      <= w_y_nxt;
                r_base_y <= w_base_nxt;
                r_state  <= w_state_nxt;
                r_facing <= w_facing_nxt;
            end
        end
    end

    assign o_x_pos  = r_x;
    assign o_y_pos  = r_y;
    assign o_state  = r_state;
    assign o_facing = r_facing;
    assign o_upd    = r_upd;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: each tick pushes its hand-derived
// expected position/state; a monitor pops and compares on every o_upd pulse.
module tb_sprite_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_ascii = 8'h00;
    logic       key_break = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [2:0] state;
    logic [1:0] facing;
    logic       upd;

    typedef struct {
        int x;
        int y;
        int st;
        int f;
        int id;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_tick = 0;

    localparam logic [7:0] K_W = 8'h77, K_A = 8'h61, K_D = 8'h64, K_SP = 8'h20;

    sprite_motion_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_key_valid (key_valid),
        .i_key_ascii (key_ascii),
        .i_key_break (key_break),
        .i_frame_tick(frame_tick),
        .o_x_pos     (x_pos),
        .o_y_pos     (y_pos),
        .o_state     (state),
        .o_facing    (facing),
        .o_upd       (upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (tick %0d): got %0d, expected %0d", name, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (upd) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL upd_unexpected: got o_upd=1, expected no pending update");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("x_pos",  e.id, int'(x_pos),  e.x);
                chk("y_pos",  e.id, int'(y_pos),  e.y);
                chk("state",  e.id, int'(state),  e.st);
                chk("facing", e.id, int'(facing), e.f);
            end
        end
    end

    task automatic push(input int ex, input int ey, input int es, input int ef);
        exp_t e;
        n_tick++;
        e.x = ex; e.y = ey; e.st = es; e.f = ef; e.id = n_tick;
        q.push_back(e);
    endtask

    task automatic tick(input int ex, input int ey, input int es, input int ef);
        push(ex, ey, es, ef);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
    endtask

    task automatic key(input logic [7:0] code, input logic brk);
        @(posedge clk); #1;
        key_valid = 1'b1; key_ascii = code; key_break = brk;
        @(posedge clk); #1 key_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_x"},      0, int'(x_pos),  304);
        chk({tag, "_y"},      0, int'(y_pos),  224);
        chk({tag, "_state"},  0, int'(state),  0);
        chk({tag, "_facing"}, 0, int'(facing), 0);
        chk({tag, "_upd"},    0, int'(upd),    0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_reset_outputs("reset");

        // Idle tick still pulses o_upd
        tick(304, 224, 0, 0);

        // Walk right 10 ticks, then release
        key(K_D, 1'b0);
        for (int i = 1; i <= 10; i++) tick(304 + 4 * i, 224, 1, 0);
        key(K_D, 1'b1);
        tick(344, 224, 0, 0);

        // Left saturation at 0, then right saturation at 608
        do_reset();
        key(K_A, 1'b0);
        for (int i = 1; i <= 80; i++) tick((304 - 4 * i < 0) ? 0 : 304 - 4 * i, 224, 1, 1);
        key(K_A, 1'b1);
        key(K_D, 1'b0);
        for (int i = 1; i <= 153; i++) tick((4 * i > 608) ? 608 : 4 * i, 224, 1, 0);
        key(K_D, 1'b1);
        tick(608, 224, 0, 0);

        // Opposite keys cancel; facing kept from the previous up move
        key(K_W, 1'b0);
        tick(608, 220, 1, 2);
        key(K_W, 1'b1);
        key(K_A, 1'b0);
        key(K_D, 1'b0);
        tick(608, 220, 0, 2);
        key(K_A, 1'b1);
        key(K_D, 1'b1);

        // Full jump from 224 with a redundant space press mid-air
        do_reset();
        key(K_SP, 1'b0);
        tick(304, 224, 2, 0);
        for (int i = 1; i <= 8; i++) begin
            tick(304, 224 - 8 * i, (i == 8) ? 3 : 2, 0);
            if (i == 3) key(K_SP, 1'b0);
        end
        for (int i = 1; i <= 8; i++) tick(304, 160 + 8 * i, (i == 8) ? 0 : 3, 0);
        tick(304, 224, 0, 0);

        // Jump near the top edge clamps at 0
        do_reset();
        key(K_W, 1'b0);
        for (int i = 1; i <= 46; i++) tick(304, 224 - 4 * i, 1, 2);
        key(K_W, 1'b1);
        key(K_SP, 1'b0);
        tick(304, 40, 2, 2);
        for (int i = 1; i <= 5; i++) tick(304, 40 - 8 * i, (i == 5) ? 3 : 2, 2);
        for (int i = 1; i <= 5; i++) tick(304, 8 * i, (i == 5) ? 0 : 3, 2);

        // Key press coinciding with a tick takes effect on the next tick
        do_reset();
        push(304, 224, 0, 0);
        @(posedge clk); #1;
        key_valid = 1'b1; key_ascii = K_D; key_break = 1'b0; frame_tick = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0; frame_tick = 1'b0;
        tick(308, 224, 1, 0);
        key(K_D, 1'b1);

        // Reset mid-jump abandons the jump
        key(K_SP, 1'b0);
        tick(308, 224, 2, 0);
        tick(308, 216, 2, 0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk_reset_outputs("midjump_reset");
        tick(304, 224, 0, 0);

        // Back-to-back ticks
        key(K_D, 1'b0);
        push(308, 224, 1, 0);
        push(312, 224, 1, 0);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 frame_tick = 1'b0;

        // Outputs held between ticks
        repeat (4) @(posedge clk);
        #1;
        chk("hold_x", 0, int'(x_pos), 312);
        chk("hold_upd", 0, int'(upd), 0);
        chk("queue_drained", 0, q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
